// File: rtl/pe_ctx_sequencer_pkg.sv
// rtl/pe_ctx_sequencer_pkg.sv - shared widths, entry layout and FSM encoding for the context sequencer
package pe_ctx_sequencer_pkg;

    // Global width defaults
    localparam int DATA_W_DEF = 16;
    localparam int NCTX_DEF   = 8;
    localparam int CTX_W_DEF  = 3;
    localparam int CNT_W_DEF  = 8;

    // Entry field positions within a table data word
    localparam int LAST_BIT = DATA_W_DEF - 1;
    localparam int CNT_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/pe_ctx_sequencer_if.sv
// rtl/pe_ctx_sequencer_if.sv - microcontroller and PE-array signal bundle for the context sequencer
interface pe_ctx_sequencer_if
    import pe_ctx_sequencer_pkg::*;
#(
    parameter int CTX_W  = CTX_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              run;
    logic              abort;
    logic              tbl_we;
    logic [CTX_W-1:0]  tbl_adr;
    logic [DATA_W-1:0] tbl_wd;
    logic [DATA_W-1:0] tbl_rd;
    logic [CTX_W-1:0]  ctx_sel;
    logic              conf_load;
    logic              arr_en;
    logic              busy;
    logic              done;
    logic              err;

    // Microcontroller side: drives table writes and run/abort, observes everything else
    modport master (
        output run, abort, tbl_we, tbl_adr, tbl_wd,
        input  tbl_rd, ctx_sel, conf_load, arr_en, busy, done, err
    );

    // Sequencer side
    modport slave (
        input  run, abort, tbl_we, tbl_adr, tbl_wd,
        output tbl_rd, ctx_sel, conf_load, arr_en, busy, done, err
    );
endinterface

// File: rtl/pe_ctx_sequencer_ctx_table.sv
// rtl/pe_ctx_sequencer_ctx_table.sv - NCTX x (last,count) register file, one write and two read ports
module ctx_table
    import pe_ctx_sequencer_pkg::*;
#(
    parameter int NCTX  = NCTX_DEF,
    parameter int CTX_W = CTX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [CTX_W-1:0] wadr,
    input  logic             wlast,
    input  logic [CNT_W-1:0] wcnt,
    input  logic [CTX_W-1:0] adr_a,
    output logic             last_a,
    output logic [CNT_W-1:0] cnt_a,
    input  logic [CTX_W-1:0] adr_b,
    output logic             last_b,
    output logic [CNT_W-1:0] cnt_b
);
    // Each word is {last, count}
    logic [CNT_W:0] mem_q [NCTX];
    logic [CNT_W:0] mem_d [NCTX];

    // Next table contents: only the addressed word changes on a write
    always_comb begin
        for (int i = 0; i < NCTX; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[wadr] = {wlast, wcnt};
        end
    end

    // Table storage, cleared by reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCTX; i++) begin
            if (rst) mem_q[i] <= '0;
            else     mem_q[i] <= mem_d[i];
        end
    end

    assign last_a = mem_q[adr_a][CNT_W];
    assign cnt_a  = mem_q[adr_a][CNT_W-1:0];
    assign last_b = mem_q[adr_b][CNT_W];
    assign cnt_b  = mem_q[adr_b][CNT_W-1:0];
endmodule

// File: rtl/pe_ctx_sequencer.sv
// rtl/pe_ctx_sequencer.sv - steps the PE array through configuration contexts from an execution table
module pe_ctx_sequencer
    import pe_ctx_sequencer_pkg::*;
#(
    parameter int NCTX   = NCTX_DEF,
    parameter int CTX_W  = CTX_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    pe_ctx_sequencer_if.slave  bus
);
    state_e           state_q, state_d;
    logic [CTX_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             err_q,   err_d;

    logic             last_a, last_b;
    logic [CNT_W-1:0] cnt_a,  cnt_b;
    logic             tbl_we_idle;
    logic             unused_wd_bits;

    // The table is frozen while a sequence runs
    assign tbl_we_idle    = bus.tbl_we && (state_q == ST_IDLE);
    assign unused_wd_bits = ^bus.tbl_wd[DATA_W-2:CNT_W];

    ctx_table #(
        .NCTX  (NCTX),
        .CTX_W (CTX_W),
        .CNT_W (CNT_W)
    ) u_ctx_table (
        .clk    (clk),
        .rst    (rst),
        .we     (tbl_we_idle),
        .wadr   (bus.tbl_adr),
        .wlast  (bus.tbl_wd[DATA_W-1]),
        .wcnt   (bus.tbl_wd[CNT_LSB +: CNT_W]),
        .adr_a  (bus.tbl_adr),
        .last_a (last_a),
        .cnt_a  (cnt_a),
        .adr_b  (ptr_q),
        .last_b (last_b),
        .cnt_b  (cnt_b)
    );

    // Readback word: last flag in the top bit, count in the low bits, rest zero
    always_comb begin
        bus.tbl_rd              = '0;
        bus.tbl_rd[DATA_W-1]    = last_a;
        bus.tbl_rd[CNT_W-1:0]   = cnt_a;
    end

    // Sequencer next state: abort wins over the LOAD/EXEC transitions, pointer never wraps
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    ptr_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d = cnt_b;
                if (bus.abort) begin
                    state_d = ST_FIN;
                end else if (cnt_b == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (bus.abort) begin
                    state_d = ST_FIN;
                end else if (cnt_q == CNT_W'(1)) begin
                    if (last_b || (ptr_q == CTX_W'(NCTX - 1))) begin
                        state_d = ST_FIN;
                    end else begin
                        ptr_d   = ptr_q + CTX_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs depend only on registered state, so the PE array sees no input-to-output path
    assign bus.ctx_sel   = ptr_q;
    assign bus.conf_load = (state_q == ST_LOAD);
    assign bus.arr_en    = (state_q == ST_EXEC);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_FIN);
    assign bus.err       = err_q;
endmodule
